// File: rtl/alu_md_ctrl.sv
// ALU control decoder plus an iterative multiply/divide unit with its HI/LO registers.
// The unit runs one shift-add or restoring-subtract step per cycle on operand magnitudes.
module alu_md_ctrl #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       funct,
  input  logic [1:0]       alu_ct_op,
  input  logic             issue,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  output logic [3:0]       alu_ct,
  output logic             md_busy,
  output logic             stall,
  output logic [WIDTH-1:0] md_rdata
);

  localparam logic [5:0] FnMfhi = 6'b010000;
  localparam logic [5:0] FnMflo = 6'b010010;
  localparam logic [CNT_W-1:0] CntLoad = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

  typedef enum logic [1:0] {StIdle, StMul, StDiv} state_e;

  state_e           state_q, state_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]   acc_q, acc_d;
  logic [WIDTH-1:0] mpl_q, mpl_d;
  logic [WIDTH-1:0] opd_q, opd_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             neg_res_q, neg_res_d;
  logic             neg_rem_q, neg_rem_d;
  logic             div_zero_q, div_zero_d;

  // MD class is 01x0xx under the R-type ALU class.
  logic is_md, accept, signed_op, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

  assign is_md     = (alu_ct_op == 2'b10) && (funct[5:4] == 2'b01) && !funct[2];
  assign accept    = issue && is_md && !busy_q;
  assign signed_op = !funct[0];
  assign a_neg     = signed_op && rs_val[WIDTH-1];
  assign b_neg     = signed_op && rt_val[WIDTH-1];
  assign a_mag     = a_neg ? -rs_val : rs_val;
  assign b_mag     = b_neg ? -rt_val : rt_val;

  assign stall   = rst && issue && is_md && busy_q;
  assign md_busy = busy_q;

  always_comb begin
    md_rdata = '0;
    if (rst) begin
      if (funct == FnMfhi) md_rdata = hi_q;
      else if (funct == FnMflo) md_rdata = lo_q;
    end
  end

  always_comb begin
    alu_ct = 4'b0000;
    if (rst) begin
      unique case (alu_ct_op)
        2'b00: alu_ct = 4'b0010;
        2'b01: alu_ct = 4'b0110;
        2'b11: alu_ct = 4'b0000;
        2'b10: begin
          case (funct)
            6'b100001: alu_ct = 4'b0010;
            6'b100011: alu_ct = 4'b0110;
            6'b100100: alu_ct = 4'b0000;
            6'b100101: alu_ct = 4'b0001;
            6'b100111: alu_ct = 4'b1100;
            6'b101010: alu_ct = 4'b0111;
            6'b101011: alu_ct = 4'b1111;
            default:   alu_ct = 4'b0000;
          endcase
        end
        default: alu_ct = 4'b0000;
      endcase
    end
  end

  // One engine step. Multiply shifts {acc, mpl} right after a conditional add;
  // divide shifts {acc, mpl} left and subtracts the divisor when it fits.
  logic [WIDTH:0]   mul_sum, div_sh;
  logic             div_ge;
  logic [WIDTH:0]   step_acc;
  logic [WIDTH-1:0] step_mpl;

  assign mul_sum = acc_q + (mpl_q[0] ? {1'b0, opd_q} : {(WIDTH+1){1'b0}});
  assign div_sh  = {acc_q[WIDTH-1:0], mpl_q[WIDTH-1]};
  assign div_ge  = div_sh >= {1'b0, opd_q};

  always_comb begin
    if (state_q == StDiv) begin
      step_acc = div_ge ? (div_sh - {1'b0, opd_q}) : div_sh;
      step_mpl = {mpl_q[WIDTH-2:0], div_ge};
    end else begin
      step_acc = {1'b0, mul_sum[WIDTH:1]};
      step_mpl = {mul_sum[0], mpl_q[WIDTH-1:1]};
    end
  end

  // Sign fix-up applied to the final step's result on the completing edge.
  logic [2*WIDTH-1:0] prod_mag, prod_res;
  logic [WIDTH-1:0]   quo_res, rem_res;

  assign prod_mag = {step_acc[WIDTH-1:0], step_mpl};
  assign prod_res = neg_res_q ? -prod_mag : prod_mag;
  assign quo_res  = div_zero_q ? {WIDTH{1'b1}} : (neg_res_q ? -step_mpl : step_mpl);
  assign rem_res  = neg_rem_q ? -step_acc[WIDTH-1:0] : step_acc[WIDTH-1:0];

  always_comb begin
    state_d    = state_q;
    busy_d     = busy_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    mpl_d      = mpl_q;
    opd_d      = opd_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    neg_res_d  = neg_res_q;
    neg_rem_d  = neg_rem_q;
    div_zero_d = div_zero_q;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (funct[3]) begin
            busy_d     = 1'b1;
            cnt_d      = CntLoad;
            acc_d      = '0;
            neg_res_d  = a_neg ^ b_neg;
            neg_rem_d  = a_neg;
            div_zero_d = (rt_val == '0);
            if (funct[1]) begin
              state_d = StDiv;
              mpl_d   = a_mag;
              opd_d   = b_mag;
            end else begin
              state_d = StMul;
              mpl_d   = b_mag;
              opd_d   = a_mag;
            end
          end else if (funct[0]) begin
            if (funct[1]) lo_d = rs_val;
            else          hi_d = rs_val;
          end
        end
      end
      StMul, StDiv: begin
        acc_d = step_acc;
        mpl_d = step_mpl;
        cnt_d = cnt_q - CntOne;
        if (cnt_q == CntOne) begin
          state_d = StIdle;
          busy_d  = 1'b0;
          if (state_q == StDiv) begin
            hi_d = rem_res;
            lo_d = quo_res;
          end else begin
            hi_d = prod_res[2*WIDTH-1:WIDTH];
            lo_d = prod_res[WIDTH-1:0];
          end
        end
      end
      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      busy_q     <= 1'b0;
      cnt_q      <= '0;
      acc_q      <= '0;
      mpl_q      <= '0;
      opd_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      mpl_q      <= mpl_d;
      opd_q      <= opd_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      neg_res_q  <= neg_res_d;
      neg_rem_q  <= neg_rem_d;
      div_zero_q <= div_zero_d;
    end
  end

endmodule

// File: tb/tb_alu_md_ctrl.sv
// Self-checking bench for alu_md_ctrl: decode table, directed MD vectors,
// stall/reset corner sequences and randomized MD ops against an arithmetic model.
module tb_alu_md_ctrl;

  localparam logic [5:0] MULT  = 6'b011000;
  localparam logic [5:0] MULTU = 6'b011001;
  localparam logic [5:0] DIV   = 6'b011010;
  localparam logic [5:0] DIVU  = 6'b011011;
  localparam logic [5:0] MFHI  = 6'b010000;
  localparam logic [5:0] MTHI  = 6'b010001;
  localparam logic [5:0] MFLO  = 6'b010010;
  localparam logic [5:0] MTLO  = 6'b010011;
  localparam logic [5:0] ADDU  = 6'b100001;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  funct;
  logic [1:0]  alu_ct_op;
  logic        issue;
  logic [31:0] rs_val, rt_val;
  logic [3:0]  alu_ct;
  logic        md_busy, stall;
  logic [31:0] md_rdata;

  int n_chk  = 0;
  int n_fail = 0;

  alu_md_ctrl #(.WIDTH(32), .CNT_W(6)) dut (
    .clk       (clk),
    .rst       (rst),
    .funct     (funct),
    .alu_ct_op (alu_ct_op),
    .issue     (issue),
    .rs_val    (rs_val),
    .rt_val    (rt_val),
    .alu_ct    (alu_ct),
    .md_busy   (md_busy),
    .stall     (stall),
    .md_rdata  (md_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [1:0] op;
    logic [5:0] fn;
    logic [3:0] exp;
  } dec_vec_t;

  typedef struct {
    logic [5:0]  fn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } md_vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic read_hilo(output logic [31:0] hi, output logic [31:0] lo);
    issue = 1'b0;
    alu_ct_op = 2'b10;
    funct = MFHI;
    #1 hi = md_rdata;
    funct = MFLO;
    #1 lo = md_rdata;
  endtask

  task automatic run_md(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                        output int cycles);
    alu_ct_op = 2'b10;
    funct = f;
    rs_val = a;
    rt_val = b;
    issue = 1'b1;
    tick();
    issue = 1'b0;
    cycles = 0;
    while (md_busy && cycles < 100) begin
      tick();
      cycles++;
    end
  endtask

  // Reference results from plain integer arithmetic; returns {HI, LO}.
  function automatic logic [63:0] md_model(input logic [5:0] f, input logic [31:0] a,
                                           input logic [31:0] b);
    longint          sa, sb, q, r;
    longint unsigned ua, ub;
    logic [63:0]     res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (f)
      MULT:  res = sa * sb;
      MULTU: res = ua * ub;
      DIVU:  res = (b == 0) ? {a, 32'hFFFFFFFF} : {a % b, a / b};
      default: begin
        if (b == 0) res = {a, 32'hFFFFFFFF};
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF) res = {32'h0, a};
        else begin
          q = sa / sb;
          r = sa % sb;
          res = {r[31:0], q[31:0]};
        end
      end
    endcase
    return res;
  endfunction

  dec_vec_t dec_tab[$];
  md_vec_t  md_tab[$];

  initial begin
    logic [31:0] hi, lo, old_hi, old_lo, a, b;
    logic [5:0]  f;
    logic [63:0] exp;
    int          cyc, n;

    dec_tab = '{
      '{2'b00, 6'b000000, 4'b0010}, '{2'b01, 6'b100101, 4'b0110}, '{2'b11, 6'b101011, 4'b0000},
      '{2'b10, 6'b100001, 4'b0010}, '{2'b10, 6'b100011, 4'b0110}, '{2'b10, 6'b100100, 4'b0000},
      '{2'b10, 6'b100101, 4'b0001}, '{2'b10, 6'b100111, 4'b1100}, '{2'b10, 6'b101010, 4'b0111},
      '{2'b10, 6'b101011, 4'b1111}, '{2'b10, 6'b000000, 4'b0000}, '{2'b10, 6'b011000, 4'b0000}
    };
    md_tab = '{
      '{MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001},
      '{MULT,  32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1},
      '{DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD},
      '{DIVU,  32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF},
      '{DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000},
      '{DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD},
      '{DIV,   32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'hFFFFFFFF},
      '{MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000}
    };

    // Reset: outputs forced low regardless of inputs.
    rst = 1'b0;
    alu_ct_op = 2'b00;
    funct = MFHI;
    issue = 1'b1;
    rs_val = 32'h12345678;
    rt_val = 32'h0;
    #3;
    chk("rst_alu_ct", {60'b0, alu_ct}, 64'h0);
    chk("rst_busy", {63'b0, md_busy}, 64'h0);
    alu_ct_op = 2'b10;
    #1;
    chk("rst_stall", {63'b0, stall}, 64'h0);
    chk("rst_rdata", {32'b0, md_rdata}, 64'h0);

    // First edge after release accepts mthi; mfhi reads it straight back.
    #8 rst = 1'b1;
    funct = MTHI;
    tick();
    read_hilo(hi, lo);
    chk("mthi_mfhi", {32'b0, hi}, 64'h12345678);
    chk("lo_after_reset", {32'b0, lo}, 64'h0);
    funct = MTLO;
    rs_val = 32'hAAAA5555;
    issue = 1'b1;
    tick();
    read_hilo(hi, lo);
    chk("mtlo_mflo", {32'b0, lo}, 64'hAAAA5555);

    foreach (dec_tab[i]) begin
      alu_ct_op = dec_tab[i].op;
      funct = dec_tab[i].fn;
      #1;
      chk($sformatf("decode_%0d", i), {60'b0, alu_ct}, {60'b0, dec_tab[i].exp});
    end

    foreach (md_tab[i]) begin
      run_md(md_tab[i].fn, md_tab[i].a, md_tab[i].b, cyc);
      read_hilo(hi, lo);
      chk($sformatf("md_cycles_%0d", i), 64'(cyc), 64'd32);
      chk($sformatf("md_hi_%0d", i), {32'b0, hi}, {32'b0, md_tab[i].hi});
      chk($sformatf("md_lo_%0d", i), {32'b0, lo}, {32'b0, md_tab[i].lo});
    end

    // mflo/mfhi held during busy stall and see old HI/LO; addu does not stall.
    read_hilo(old_hi, old_lo);
    alu_ct_op = 2'b10;
    funct = MULTU;
    rs_val = 32'h1234;
    rt_val = 32'h10;
    issue = 1'b1;
    tick();
    funct = MFLO;
    n = 0;
    while (md_busy && n < 100) begin
      chk("busy_stall", {63'b0, stall}, 64'h1);
      chk("busy_lo_hold", {32'b0, md_rdata}, {32'b0, old_lo});
      if (n == 5) begin
        funct = ADDU;
        #1;
        chk("addu_no_stall", {63'b0, stall}, 64'h0);
        chk("addu_alu_ct", {60'b0, alu_ct}, 64'h2);
        funct = MFHI;
        #1;
        chk("busy_hi_hold", {32'b0, md_rdata}, {32'b0, old_hi});
        funct = MFLO;
      end
      tick();
      n++;
    end
    chk("stall_busy_len", 64'(n), 64'd32);
    chk("stall_release", {63'b0, stall}, 64'h0);
    chk("new_lo", {32'b0, md_rdata}, 64'h12340);
    issue = 1'b0;

    // Reset in the middle of a mult aborts it with no late HI/LO write.
    funct = MULT;
    rs_val = 32'hFFFFFFFD;
    rt_val = 32'h7;
    issue = 1'b1;
    tick();
    issue = 1'b0;
    repeat (9) tick();
    chk("busy_before_abort", {63'b0, md_busy}, 64'h1);
    #2 rst = 1'b0;
    #1;
    chk("abort_busy", {63'b0, md_busy}, 64'h0);
    #3 rst = 1'b1;
    repeat (40) tick();
    read_hilo(hi, lo);
    chk("abort_hi", {32'b0, hi}, 64'h0);
    chk("abort_lo", {32'b0, lo}, 64'h0);
    chk("abort_idle", {63'b0, md_busy}, 64'h0);

    // Fresh mult accepted on the first edge after a reset release.
    #1 rst = 1'b0;
    #2 rst = 1'b1;
    alu_ct_op = 2'b10;
    funct = MULT;
    rs_val = 32'h6;
    rt_val = 32'h7;
    issue = 1'b1;
    tick();
    issue = 1'b0;
    chk("accept_after_rst", {63'b0, md_busy}, 64'h1);
    n = 0;
    while (md_busy && n < 100) begin
      tick();
      n++;
    end
    read_hilo(hi, lo);
    chk("post_rst_mult", {hi, lo}, 64'd42);

    for (int k = 0; k < 24; k++) begin
      f = {4'b0110, 2'($urandom_range(0, 3))};
      a = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'h0;
        1: b = $urandom_range(1, 9);
        2: b = 32'hFFFFFFFF;
        default: b = $urandom;
      endcase
      if (k % 8 == 3) a = 32'h80000000;
      run_md(f, a, b, cyc);
      read_hilo(hi, lo);
      exp = md_model(f, a, b);
      chk($sformatf("rand_cycles_%0d", k), 64'(cyc), 64'd32);
      chk($sformatf("rand_%0d_f%0h_a%0h_b%0h", k, f, a, b), {hi, lo}, exp);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_md_ctrl.md
ALU_MD_CTRL -- requirements
Module: alu_md_ctrl

Parameters
REQ-001 SHALL have parameter WIDTH, default 32, datapath width in bits; legal values 8..64, even.
REQ-002 SHALL have parameter CNT_W, default 6, iteration counter width; SHALL satisfy 2**CNT_W > WIDTH.

Interface
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 funct  input  6  R-type function field.
REQ-006 alu_ct_op  input  2  main-decoder ALU class.
REQ-007 issue  input  1  instruction valid in decode this cycle.
REQ-008 rs_val  input  WIDTH  operand A.
REQ-009 rt_val  input  WIDTH  operand B.
REQ-010 alu_ct  output  4  ALU control code, combinational.
REQ-011 md_busy  output  1  multiply/divide iteration in progress, registered.
REQ-012 stall  output  1  hold pipeline this cycle, combinational.
REQ-013 md_rdata  output  WIDTH  HI or LO read value, combinational.

Function
REQ-014 alu_ct SHALL decode as follows: alu_ct_op 00 -> 0010; 01 -> 0110; 11 -> 0000.
REQ-015 For alu_ct_op 10, funct SHALL decode as: 100001 -> 0010, 100011 -> 0110, 100100 -> 0000, 100101 -> 0001, 100111 -> 1100, 101010 -> 0111, 101011 -> 1111; any other funct -> 0000.
REQ-016 MD class (alu_ct_op=10 only) SHALL comprise: mult 011000, multu 011001, div 011010, divu 011011, mfhi 010000, mthi 010001, mflo 010010, mtlo 010011.
REQ-017 stall SHALL be 1 iff issue=1, the funct is in the MD class, and md_busy=1; otherwise stall SHALL be 0.
REQ-018 Accept SHALL mean issue=1 with an MD-class funct and stall=0; non-accepted MD instructions SHALL have no effect.
REQ-019 Accepted mult/multu/div/divu SHALL latch operands and load the counter with WIDTH; md_busy SHALL be 1 from the following cycle.
REQ-020 Engine SHALL perform one shift-add (mult) or one restoring-subtract (div) step per cycle on operand magnitudes, decrementing the counter by 1 per step.
REQ-021 On the edge where the counter goes 1->0, the engine SHALL write HI/LO and clear md_busy; md_busy SHALL be high exactly WIDTH cycles.
REQ-022 mult/multu SHALL produce {HI,LO} = the 2*WIDTH-bit signed/unsigned product.
REQ-023 div/divu SHALL produce LO = quotient truncated toward zero and HI = remainder; a nonzero signed remainder SHALL take the sign of the dividend.
REQ-024 Divide by zero SHALL produce LO = all ones and HI = dividend, with full WIDTH latency.
REQ-025 Signed div of most-negative by -1 SHALL produce LO = most-negative and HI = 0.
REQ-026 Accepted mthi/mtlo SHALL write rs_val into HI/LO on that edge.
REQ-027 md_rdata SHALL equal HI when funct=010000, LO when funct=010010, and 0 otherwise; it SHALL show pre-edge register contents.
REQ-028 HI/LO SHALL hold their previous values throughout md_busy=1.
REQ-029 issue with a non-MD funct while md_busy=1 SHALL neither stall nor disturb the engine.

Reset
REQ-030 While rst=0, the block SHALL immediately force HI=0, LO=0, md_busy=0, counter=0, and operand/partial registers to 0.
REQ-031 While rst=0, alu_ct, stall and md_rdata SHALL be 0 regardless of inputs.
REQ-032 Reset asserted mid-operation SHALL abort the operation; no HI/LO write SHALL occur after rst returns to 1.
REQ-033 The first accept SHALL be possible on the first rising edge with rst=1.

Verification (WIDTH=32)
REQ-034 Decode sweep: alu_ct_op 00/01/11 and every funct listed in REQ-015 plus 6'b000000 -> codes exactly as in REQ-014/015.
REQ-035 multu 0xFFFFFFFF x 0xFFFFFFFF -> md_busy high exactly 32 cycles; then HI=0xFFFFFFFE, LO=0x00000001. mult -3 x 5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1.
REQ-036 div -7 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu 7 / 0 -> LO=0xFFFFFFFF, HI=7. div 0x80000000 / -1 -> LO=0x80000000, HI=0.
REQ-037 mflo issued during busy -> stall=1 each busy cycle and HI/LO unchanged; stall=0 on the first cycle after busy falls, with md_rdata = new LO. addu issued during busy -> stall=0.
REQ-038 rst pulsed low at busy cycle 10 of a mult -> HI=LO=0, md_busy=0 asynchronously; no later HI/LO write; a new mult accepts on the next edge after release.
REQ-039 mthi 0x12345678 then mfhi on the next cycle -> md_rdata=0x12345678.
